// File: rtl/if_fetch_predict.sv
// if_fetch_predict: fetch stage with BHT/predecode next-PC prediction, stall hold buffer and flush drain.
module if_fetch_predict #(
  parameter int width = 32,
  parameter int BHT_IDX = 6,
  parameter logic [width-1:0] RESET_PC = 'h60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IF_stall_i,
  input  logic             ID_flush_i,
  input  logic [width-1:0] ID_branch_pc_i,
  input  logic             ID_is_br_i,
  input  logic             ID_br_en_i,
  input  logic [width-1:0] ID_pc_i,
  input  logic             imem_resp_i,
  input  logic [width-1:0] imem_rdata_i,
  output logic             imem_read_o,
  output logic [width-1:0] imem_address_o,
  output logic [width-1:0] IF_instr_o,
  output logic [width-1:0] IF_pc_out_o,
  output logic             IF_br_pred_o,
  output logic             IF_valid_o
);
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
  state_t state;
  logic [width-1:0] pc, redirect_q, buf_instr, buf_next, tgt, next_pc;
  logic buf_pred, is_jal, is_br, pred;
  logic [1:0] bht [2**BHT_IDX];
  logic [1:0] upd;
  logic [BHT_IDX-1:0] rd_idx, wr_idx;
  logic [20:0] j_imm;
  logic [12:0] b_imm;
  logic unused_ok;
  assign unused_ok = ^{ID_pc_i[width-1:BHT_IDX+2], ID_pc_i[1:0]};
  assign rd_idx = pc[BHT_IDX+1:2];
  assign wr_idx = ID_pc_i[BHT_IDX+1:2];
  assign j_imm = {imem_rdata_i[31], imem_rdata_i[19:12], imem_rdata_i[20], imem_rdata_i[30:21], 1'b0};
  assign b_imm = {imem_rdata_i[31], imem_rdata_i[7], imem_rdata_i[30:25], imem_rdata_i[11:8], 1'b0};
  assign is_jal = imem_rdata_i[6:0] == 7'b1101111;
  assign is_br = imem_rdata_i[6:0] == 7'b1100011;
  assign pred = is_jal | (is_br & bht[rd_idx][1]);
  assign tgt = pc + (is_jal ? {{(width-21){j_imm[20]}}, j_imm} : {{(width-13){b_imm[12]}}, b_imm});
  assign next_pc = pred ? tgt : pc + width'(4);
  assign upd = ID_br_en_i ? (bht[wr_idx] == 2'b11 ? 2'b11 : bht[wr_idx] + 2'b01)
                          : (bht[wr_idx] == 2'b00 ? 2'b00 : bht[wr_idx] - 2'b01);
  assign imem_address_o = pc;
  assign imem_read_o = ~rst & (state != HOLD);
  assign IF_valid_o = ~rst & (state == HOLD | (state == FETCH & imem_resp_i & ~ID_flush_i));
  assign IF_instr_o = rst ? '0 : state == HOLD ? buf_instr : imem_rdata_i;
  assign IF_br_pred_o = ~rst & (state == HOLD ? buf_pred : pred);
  assign IF_pc_out_o = pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      state <= FETCH;
      redirect_q <= '0;
      buf_instr <= '0;
      buf_next <= '0;
      buf_pred <= 1'b0;
      for (int i = 0; i < 2**BHT_IDX; i++) bht[i] <= 2'b01;
    end else begin
      if (ID_is_br_i & ~IF_stall_i) bht[wr_idx] <= upd;
      unique case (state)
        FETCH:
          if (imem_resp_i & ID_flush_i) pc <= ID_branch_pc_i;
          else if (imem_resp_i & IF_stall_i) begin
            buf_instr <= imem_rdata_i;
            buf_pred <= pred;
            buf_next <= next_pc;
            state <= HOLD;
          end else if (imem_resp_i) pc <= next_pc;
          else if (ID_flush_i) begin
            redirect_q <= ID_branch_pc_i;
            state <= DRAIN;
          end
        HOLD:
          if (ID_flush_i | ~IF_stall_i) begin
            pc <= ID_flush_i ? ID_branch_pc_i : buf_next;
            state <= FETCH;
          end
        DRAIN:
          if (imem_resp_i) begin
            pc <= ID_flush_i ? ID_branch_pc_i : redirect_q;
            state <= FETCH;
          end else if (ID_flush_i) redirect_q <= ID_branch_pc_i;
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_if_fetch_predict.sv
// tb_if_fetch_predict: directed scenarios plus random traffic checked every cycle against a behavioural fetch model.
module tb_if_fetch_predict;
  logic clk = 0, rst = 1, stall = 0, flush = 0, is_br = 0, br_en = 0, resp = 0;
  logic [31:0] bpc = 0, idpc = 0, rdata = 0;
  logic read, br_pred, valid;
  logic [31:0] addr, instr, pc_out;
  int checks = 0, errors = 0;
  logic [31:0] mpc = 0, bi = 0, bn = 0, mr = 0;
  int mode = 0;
  bit bp = 0, known = 0;
  int bht [64];
  logic [31:0] dmem [logic [31:0]];

  if_fetch_predict dut (
    .clk(clk), .rst(rst), .IF_stall_i(stall), .ID_flush_i(flush), .ID_branch_pc_i(bpc),
    .ID_is_br_i(is_br), .ID_br_en_i(br_en), .ID_pc_i(idpc), .imem_resp_i(resp),
    .imem_rdata_i(rdata), .imem_read_o(read), .imem_address_o(addr), .IF_instr_o(instr),
    .IF_pc_out_o(pc_out), .IF_br_pred_o(br_pred), .IF_valid_o(valid)
  );

  always #5 clk = ~clk;

  task automatic cmp(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [31:0] mem(logic [31:0] a);
    logic [31:0] h;
    if (dmem.exists(a)) return dmem[a];
    h = a * 32'h9E3779B1;
    h = (h ^ (h >> 15)) * 32'h85EBCA6B;
    case (h[1:0])
      2'd0: return {h[31:7], 7'h13};
      2'd1: return {h[31:7], 7'h6F};
      2'd2: return {h[31:7], 7'h63};
      default: return {h[31:7], 7'h67};
    endcase
  endfunction

  function automatic int sx(int v, int bits);
    return v >= (1 << (bits - 1)) ? v - (1 << bits) : v;
  endfunction

  function automatic bit mpred(logic [31:0] w, logic [31:0] p);
    if (w[6:0] == 7'h6F) return 1;
    if (w[6:0] == 7'h63) return bht[p[7:2]] >= 2;
    return 0;
  endfunction

  function automatic logic [31:0] mnext(logic [31:0] w, logic [31:0] p);
    int imm;
    if (!mpred(w, p)) return p + 4;
    imm = (w[6:0] == 7'h6F) ? sx(int'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21)
                            : sx(int'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13);
    return p + imm;
  endfunction

  // Compare DUT against the model for the inputs currently applied, then advance the model.
  task automatic chk();
    bit ev, p;
    logic [31:0] n;
    rdata = known ? mem(mpc) : 32'h0;
    #1;
    if (rst) begin
      cmp("rst_read", read, 0);
      cmp("rst_valid", valid, 0);
      cmp("rst_instr", instr, 0);
      cmp("rst_pred", br_pred, 0);
      if (known) cmp("rst_pc", pc_out, mpc);
    end else begin
      ev = mode == 1 || (mode == 0 && resp && !flush);
      cmp("read", read, mode != 1);
      cmp("addr", addr, mpc);
      cmp("valid", valid, ev);
      if (ev) begin
        cmp("instr", instr, mode == 1 ? bi : rdata);
        cmp("pc_out", pc_out, mpc);
        cmp("pred", br_pred, mode == 1 ? bp : mpred(rdata, mpc));
      end
    end
    if (rst) begin
      mpc = 32'h60; mode = 0; mr = 0; known = 1;
      foreach (bht[i]) bht[i] = 1;
    end else begin
      p = mpred(rdata, mpc);
      n = mnext(rdata, mpc);
      if (mode == 0) begin
        if (resp && flush) mpc = bpc;
        else if (resp && stall) begin bi = rdata; bp = p; bn = n; mode = 1; end
        else if (resp) mpc = n;
        else if (flush) begin mr = bpc; mode = 2; end
      end else if (mode == 1) begin
        if (flush) begin mpc = bpc; mode = 0; end
        else if (!stall) begin mpc = bn; mode = 0; end
      end else begin
        if (resp) begin mpc = flush ? bpc : mr; mode = 0; end
        else if (flush) mr = bpc;
      end
      if (is_br && !stall) bht[idpc[7:2]] = br_en ? (bht[idpc[7:2]] < 3 ? bht[idpc[7:2]] + 1 : 3)
                                                  : (bht[idpc[7:2]] > 0 ? bht[idpc[7:2]] - 1 : 0);
    end
  endtask

  initial begin
    dmem[32'h60] = 32'h00100093;
    dmem[32'h64] = 32'h0100006F;
    dmem[32'h74] = 32'h00100113;
    dmem[32'h80] = 32'h02000063;
    dmem[32'h84] = 32'h00100093;
    dmem[32'hA0] = 32'h00100093;
    dmem[32'h200] = 32'h00100093;
    @(negedge clk); chk();
    @(negedge clk); chk();
    cmp("t0_pc", pc_out, 32'h60);
    @(negedge clk); rst = 0; resp = 1; chk();
    cmp("t1_addr", addr, 32'h60); cmp("t1_valid", valid, 1); cmp("t1_pc", pc_out, 32'h60); cmp("t1_pred", br_pred, 0);
    @(negedge clk); chk();
    cmp("t2_addr", addr, 32'h64); cmp("t2_pred", br_pred, 1);
    @(negedge clk); stall = 1; chk();
    cmp("t3_addr", addr, 32'h74); cmp("t3_valid", valid, 1);
    @(negedge clk); chk();
    cmp("t3_read", read, 0); cmp("t3_instr", instr, 32'h00100113); cmp("t3_hvalid", valid, 1);
    @(negedge clk); chk();
    @(negedge clk); stall = 0; chk();
    @(negedge clk); resp = 0; flush = 1; bpc = 32'h200; chk();
    cmp("t3_rel_addr", addr, 32'h78); cmp("t4_valid", valid, 0);
    @(negedge clk); flush = 0; chk();
    cmp("t4_hold_addr", addr, 32'h78);
    @(negedge clk); chk();
    @(negedge clk); resp = 1; chk();
    cmp("t4_drain_valid", valid, 0);
    @(negedge clk); resp = 0; chk();
    cmp("t4_addr", addr, 32'h200);
    @(negedge clk); flush = 1; bpc = 32'h80; resp = 1; chk();
    @(negedge clk); flush = 0; chk();
    cmp("t5_pc", pc_out, 32'h80); cmp("t5_pred0", br_pred, 0);
    @(negedge clk); resp = 0; is_br = 1; idpc = 32'h80; br_en = 1; chk();
    @(negedge clk); chk();
    @(negedge clk); is_br = 0; flush = 1; bpc = 32'h80; resp = 1; chk();
    @(negedge clk); flush = 0; chk();
    cmp("t5_pc2", pc_out, 32'h80); cmp("t5_pred1", br_pred, 1);
    @(negedge clk); resp = 0; chk();
    cmp("t5_tgt", addr, 32'hA0);
    @(negedge clk); is_br = 1; br_en = 0; flush = 1; bpc = 32'h80; resp = 1; chk();
    @(negedge clk); is_br = 0; flush = 0; chk();
    cmp("t5_nt_pred", br_pred, 1);
    @(negedge clk); stall = 1; chk();
    @(negedge clk); flush = 1; bpc = 32'h300; chk();
    cmp("t6_hvalid", valid, 1);
    @(negedge clk); flush = 0; stall = 0; resp = 0; chk();
    cmp("t6_addr", addr, 32'h300); cmp("t6_valid", valid, 0);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = $urandom_range(0, 199) == 0;
      stall = $urandom_range(0, 3) == 0;
      flush = $urandom_range(0, 9) == 0;
      resp = $urandom_range(0, 9) < 6;
      is_br = $urandom_range(0, 9) < 4;
      br_en = $urandom_range(0, 1) == 1;
      idpc = {$urandom_range(0, 3), 6'($urandom), 2'b00};
      bpc = {$urandom_range(0, 1023), 2'b00};
      chk();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
